boot_loader: RTL and testbench

- Upstream stage of the 16-bit cpu.
- Holds the cpu in reset while a byte stream (valid/ready) fills instruction memory with 16-bit words.
- Verifies a trailing checksum, then releases cpu reset so execution starts from BASE_ADDR.
- Sits between the host byte link (UART/bench) and the instruction memory write port plus the cpu rst input.

---
 rtl/boot_loader.sv | 166 ++++++++++++++++
 tb/tb_boot_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Byte-stream boot loader: fills instruction memory with big-endian 16-bit words,
// verifies a trailing mod-256 checksum, then releases the cpu from reset.
module boot_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reload,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  sum_q, sum_d;
    logic [15:0] words_q, words_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        in_ready_q, in_ready_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept;
    logic [15:0] new_count;

    assign accept    = in_valid && in_ready_q;
    assign new_count = {count_q[15:8], in_data};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        hi_d        = hi_q;
        sum_d       = sum_q;
        words_d     = words_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_LEN_HI: begin
                if (accept) begin
                    count_d = {in_data, count_q[7:0]};
                    sum_d   = sum_q + in_data;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    count_d = new_count;
                    sum_d   = sum_q + in_data;
                    if (new_count > MAX_W) begin
                        state_d = S_ERR;
                    end else if (new_count == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    sum_d   = sum_q + in_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = {hi_q, in_data};
                    // Address uses the pre-increment index; 16-bit add wraps naturally.
                    mem_addr_d  = BASE_ADDR + words_q;
                    words_d     = words_q + 16'd1;
                    sum_d       = sum_q + in_data;
                    state_d     = (words_d == count_q) ? S_CHK : S_DATA_HI;
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (in_data == sum_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (reload) begin
                    state_d = S_LEN_HI;
                    words_d = 16'd0;
                    sum_d   = 8'd0;
                    count_d = 16'd0;
                end
            end
            default: begin
                state_d = S_LEN_HI;
            end
        endcase

        // Status flags are derived from the next state so they line up with it.
        in_ready_d = (state_d != S_DONE) && (state_d != S_ERR);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
        cpu_rst_d  = (state_d != S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LEN_HI;
            count_q     <= 16'd0;
            hi_q        <= 8'd0;
            sum_q       <= 8'd0;
            words_q     <= 16'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 16'd0;
            in_ready_q  <= 1'b1;
            cpu_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            hi_q        <= hi_d;
            sum_q       <= sum_d;
            words_q     <= words_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            in_ready_q  <= in_ready_d;
            cpu_rst_q   <= cpu_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_rst      = cpu_rst_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: normal, bad checksum, oversize, zero, gapped and reset runs.
module tb_boot_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        reload;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    int errors = 0;
    int checks = 0;

    logic [15:0] wr_addr [64];
    logic [15:0] wr_dat  [64];
    int          wr_n = 0;
    int          base;

    boot_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .reload       (reload),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we && wr_n < 64) begin
            wr_addr[wr_n] = mem_addr;
            wr_dat[wr_n]  = mem_wdata;
            wr_n          = wr_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        reload   = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
        chk("rst_cpu_rst",  32'(cpu_rst),  32'd1);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_err",      32'(err),      32'd0);
        chk("rst_words",    32'(words_loaded), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Normal load, back-to-back bytes.
        base = wr_n;
        send(8'h00); send(8'h02); send(8'h12); send(8'h34);
        chk("norm_we_after_lo", 32'(mem_we), 32'd1);
        send(8'hAB); send(8'hCD);
        chk("norm_words", 32'(words_loaded), 32'd2);
        chk("norm_done_before_chk", 32'(done), 32'd0);
        send(8'hC0);
        chk("norm_done",     32'(done),     32'd1);
        chk("norm_cpu_rst",  32'(cpu_rst),  32'd0);
        chk("norm_in_ready", 32'(in_ready), 32'd0);
        idle(1);
        chk("norm_wr_count", 32'(wr_n - base), 32'd2);
        chk("norm_wr0_addr", 32'(wr_addr[base]),     32'h0000);
        chk("norm_wr0_data", 32'(wr_dat[base]),      32'h1234);
        chk("norm_wr1_addr", 32'(wr_addr[base + 1]), 32'h0001);
        chk("norm_wr1_data", 32'(wr_dat[base + 1]),  32'hABCD);

        // Bad checksum.
        pulse_reload();
        chk("reload_done_clr", 32'(done), 32'd0);
        base = wr_n;
        send(8'h00); send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD); send(8'hC1);
        chk("bad_err",     32'(err),     32'd1);
        chk("bad_done",    32'(done),    32'd0);
        chk("bad_cpu_rst", 32'(cpu_rst), 32'd1);
        idle(1);
        chk("bad_wr_count", 32'(wr_n - base), 32'd2);
        send(8'h77);
        chk("err_ignores_byte", 32'(err), 32'd1);
        // Byte presented alongside reload must not be taken as count_hi.
        in_data  = 8'h01;
        in_valid = 1'b1;
        pulse_reload();
        in_valid = 1'b0;
        chk("reload_err_clr",   32'(err),          32'd0);
        chk("reload_in_ready",  32'(in_ready),     32'd1);
        chk("reload_words",     32'(words_loaded), 32'd0);
        chk("reload_cpu_rst",   32'(cpu_rst),      32'd1);

        // Zero count (also proves the byte at reload was dropped).
        base = wr_n;
        send(8'h00); send(8'h00); send(8'h00);
        chk("zero_done",    32'(done),    32'd1);
        chk("zero_cpu_rst", 32'(cpu_rst), 32'd0);
        idle(1);
        chk("zero_wr_count", 32'(wr_n - base), 32'd0);

        // Oversize count.
        pulse_reload();
        base = wr_n;
        send(8'h01); send(8'h01);
        chk("over_err",      32'(err),      32'd1);
        chk("over_in_ready", 32'(in_ready), 32'd0);
        idle(1);
        chk("over_wr_count", 32'(wr_n - base), 32'd0);

        // Gapped valid.
        pulse_reload();
        base = wr_n;
        send(8'h00); idle(3); send(8'h02); idle(3); send(8'h12); idle(3); send(8'h34); idle(3);
        send(8'hAB); idle(3); send(8'hCD); idle(3);
        chk("gap_words", 32'(words_loaded), 32'd2);
        send(8'hC0);
        chk("gap_done",     32'(done),    32'd1);
        chk("gap_cpu_rst",  32'(cpu_rst), 32'd0);
        chk("gap_wr_count", 32'(wr_n - base), 32'd2);
        chk("gap_wr0_data", 32'(wr_dat[base]),      32'h1234);
        chk("gap_wr1_addr", 32'(wr_addr[base + 1]), 32'h0001);
        chk("gap_wr1_data", 32'(wr_dat[base + 1]),  32'hABCD);

        // Async reset mid-load.
        pulse_reload();
        send(8'h00); send(8'h02); send(8'h12); send(8'h34); send(8'hAB);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_in_ready",  32'(in_ready),     32'd1);
        chk("arst_mem_we",    32'(mem_we),       32'd0);
        chk("arst_mem_addr",  32'(mem_addr),     32'h0000);
        chk("arst_mem_wdata", 32'(mem_wdata),    32'h0000);
        chk("arst_words",     32'(words_loaded), 32'd0);
        chk("arst_cpu_rst",   32'(cpu_rst),      32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fresh single-word stream.
        base = wr_n;
        send(8'h00); send(8'h01); send(8'h55); send(8'h66); send(8'hBC);
        chk("fresh_done",     32'(done),         32'd1);
        chk("fresh_cpu_rst",  32'(cpu_rst),      32'd0);
        chk("fresh_words",    32'(words_loaded), 32'd1);
        idle(1);
        chk("fresh_wr_count", 32'(wr_n - base),  32'd1);
        chk("fresh_wr_addr",  32'(wr_addr[base]), 32'h0000);
        chk("fresh_wr_data",  32'(wr_dat[base]),  32'h5566);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
